// File: rtl/l1c_arbiter.sv
// l1c_arbiter: shares one CPU-wrapper request port between the I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise D always wins.
//
// state | meaning
// IDLE  | no transaction in flight; grant a pending request
// ISSUE | mem_req driven from latched fields until mem_wait is low
// RESP  | count mem_valid beats and forward them to the owner
module l1c_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_write,
    input  logic [2:0]            i_type,
    input  logic                  i_burst,
    input  logic [DATA_W-1:0]     i_in,
    input  logic [DATA_W/8-1:0]   i_strobe,
    output logic [DATA_W-1:0]     i_out,
    output logic                  i_valid,
    output logic                  i_wait,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_write,
    input  logic [2:0]            d_type,
    input  logic                  d_burst,
    input  logic [DATA_W-1:0]     d_in,
    input  logic [DATA_W/8-1:0]   d_strobe,
    output logic [DATA_W-1:0]     d_out,
    output logic                  d_valid,
    output logic                  d_wait,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  mem_burst,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_in,
    output logic [2:0]            mem_type,
    output logic [DATA_W/8-1:0]   mem_strobe,
    input  logic [DATA_W-1:0]     mem_out,
    input  logic                  mem_wait,
    input  logic                  mem_valid
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                 state, state_next;
    logic [ADDR_W-1:0]      lat_addr;
    logic                   lat_write;
    logic                   lat_burst;
    logic [2:0]             lat_type;
    logic [DATA_W-1:0]      lat_in;
    logic [DATA_W/8-1:0]    lat_strobe;
    logic                   owner_d;
    logic                   beat_cnt;
    logic                   grant;
    logic                   grant_d;
    logic                   beat;
    logic                   last_beat;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who was served last; reset value makes D the first winner.
    logic last_was_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_was_d <= 1'b0;
        else if (grant)
            last_was_d <= grant_d;
    end

    assign grant_d = d_req && (!i_req || !last_was_d);
`else
    assign grant_d = d_req;
`endif

    assign grant     = (state == IDLE) && (i_req || d_req);
    assign beat      = (state == RESP) && mem_valid;
    // Only a burst read takes two beats; everything else finishes on the first.
    assign last_beat = beat && (!(lat_burst && !lat_write) || beat_cnt);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   if (!mem_wait) state_next = RESP;
            RESP:    if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_write  <= 1'b0;
            lat_burst  <= 1'b0;
            lat_type   <= '0;
            lat_in     <= '0;
            lat_strobe <= '0;
            owner_d    <= 1'b0;
            beat_cnt   <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                lat_addr   <= grant_d ? d_addr   : i_addr;
                lat_write  <= grant_d ? d_write  : i_write;
                lat_burst  <= grant_d ? d_burst  : i_burst;
                lat_type   <= grant_d ? d_type   : i_type;
                lat_in     <= grant_d ? d_in     : i_in;
                lat_strobe <= grant_d ? d_strobe : i_strobe;
                owner_d    <= grant_d;
                beat_cnt   <= 1'b0;
            end else if (beat) begin
                beat_cnt   <= !last_beat;
            end
        end
    end

    assign mem_req    = (state == ISSUE);
    assign mem_addr   = lat_addr;
    assign mem_write  = lat_write;
    assign mem_burst  = lat_burst;
    assign mem_type   = lat_type;
    assign mem_in     = lat_in;
    assign mem_strobe = lat_strobe;

    assign i_out   = mem_out;
    assign d_out   = mem_out;
    assign i_valid = beat && !owner_d;
    assign d_valid = beat && owner_d;
    assign i_wait  = i_req && !(last_beat && !owner_d);
    assign d_wait  = d_req && !(last_beat && owner_d);

endmodule

// File: tb/tb_l1c_arbiter.sv
// tb_l1c_arbiter: directed scoreboard bench for l1c_arbiter.
// Build with ARB_ROUND_ROBIN_EN defined to cover the round-robin variant.
`timescale 1ns/1ps
module tb_l1c_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW/8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_write, i_burst, d_req, d_write, d_burst;
    logic [AW-1:0] i_addr, d_addr;
    logic [2:0]    i_type, d_type;
    logic [DW-1:0] i_in, d_in, i_out, d_out;
    logic [SW-1:0] i_strobe, d_strobe;
    logic          i_valid, i_wait, d_valid, d_wait;
    logic          mem_req, mem_write, mem_burst, mem_wait, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in, mem_out;
    logic [2:0]    mem_type;
    logic [SW-1:0] mem_strobe;

    l1c_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_write(i_write), .i_type(i_type), .i_burst(i_burst),
        .i_in(i_in), .i_strobe(i_strobe), .i_out(i_out), .i_valid(i_valid), .i_wait(i_wait),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_type(d_type), .d_burst(d_burst),
        .d_in(d_in), .d_strobe(d_strobe), .d_out(d_out), .d_valid(d_valid), .d_wait(d_wait),
        .mem_req(mem_req), .mem_write(mem_write), .mem_burst(mem_burst), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_type(mem_type), .mem_strobe(mem_strobe),
        .mem_out(mem_out), .mem_wait(mem_wait), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic          burst;
        logic [2:0]    typ;
        logic [DW-1:0] data;
        logic [SW-1:0] strobe;
    } grant_t;

    typedef struct packed {
        logic          own_d;
        logic [DW-1:0] data;
    } beat_t;

    grant_t gq[$];
    beat_t  bq[$];
    grant_t cur_g;
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_fail = 0;
    int     req_cycles = 0;
    logic   prev_req = 1'b0;
    bit     tb_last_d = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic grant_t make_grant(input bit own_d);
        grant_t g;
        g.addr   = own_d ? d_addr   : i_addr;
        g.wr     = own_d ? d_write  : i_write;
        g.burst  = own_d ? d_burst  : i_burst;
        g.typ    = own_d ? d_type   : i_type;
        g.data   = own_d ? d_in     : i_in;
        g.strobe = own_d ? d_strobe : i_strobe;
        return g;
    endfunction

    function automatic bit pick_d();
`ifdef ARB_ROUND_ROBIN_EN
        return d_req && (!i_req || !tb_last_d);
`else
        return d_req;
`endif
    endfunction

    // Grant and beat scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            check("grant_expected", 64'(gq.size() != 0), 64'(1));
            if (gq.size() != 0) cur_g = gq.pop_front();
        end
        if (mem_req) begin
            req_cycles++;
            check("mem_addr", 64'(mem_addr), 64'(cur_g.addr));
            check("mem_write", 64'(mem_write), 64'(cur_g.wr));
            check("mem_burst", 64'(mem_burst), 64'(cur_g.burst));
            check("mem_type", 64'(mem_type), 64'(cur_g.typ));
            check("mem_in", mem_in, cur_g.data);
            check("mem_strobe", 64'(mem_strobe), 64'(cur_g.strobe));
        end
        if (i_valid || d_valid) begin
            beat_t b;
            check("valid_onehot", 64'(i_valid & d_valid), 64'(0));
            check("beat_expected", 64'(bq.size() != 0), 64'(1));
            if (bq.size() != 0) begin
                b = bq.pop_front();
                check("valid_owner", 64'(d_valid), 64'(b.own_d));
                check("rdata", d_valid ? d_out : i_out, b.data);
            end
        end
        prev_req = mem_req;
    end

    // Drives one granted transaction from its IDLE cycle through the final beat.
    task automatic serve(input bit own_d, input int stall, input bit stray,
                         input bit drop, input bit glitch, input logic [DW-1:0] base);
        grant_t g;
        beat_t  b;
        int     nb;
        g  = make_grant(own_d);
        nb = (!g.wr && g.burst) ? 2 : 1;
        gq.push_back(g);
        @(negedge clk);
        check("idle_mem_req", 64'(mem_req), 64'(0));
        check("idle_owner_wait", 64'(own_d ? d_wait : i_wait), 64'(1));
        tick();
        if (drop) begin
            if (own_d) d_req = 1'b0; else i_req = 1'b0;
        end
        if (glitch) begin
            if (own_d) i_req = 1'b1; else d_req = 1'b1;
        end
        mem_valid = stray;
        for (int s = 0; s <= stall; s++) begin
            mem_wait = (s < stall);
            @(negedge clk);
            check("issue_mem_req", 64'(mem_req), 64'(1));
            check("issue_owner_wait", 64'(own_d ? d_wait : i_wait), 64'(own_d ? d_req : i_req));
            check("issue_other_wait", 64'(own_d ? i_wait : d_wait), 64'(own_d ? i_req : d_req));
            check("issue_no_valid", 64'({i_valid, d_valid}), 64'(0));
            tick();
            if (glitch) begin
                if (own_d) i_req = 1'b0; else d_req = 1'b0;
            end
        end
        mem_wait = 1'b0;
        for (int k = 0; k < nb; k++) begin
            mem_valid = 1'b1;
            mem_out   = base + 64'(k);
            b.own_d   = own_d;
            b.data    = base + 64'(k);
            bq.push_back(b);
            @(negedge clk);
            check("resp_mem_req", 64'(mem_req), 64'(0));
            check("resp_owner_wait", 64'(own_d ? d_wait : i_wait),
                  64'((own_d ? d_req : i_req) && (k != nb - 1)));
            check("resp_other_wait", 64'(own_d ? i_wait : d_wait), 64'(own_d ? i_req : d_req));
            check("resp_valid", 64'(own_d ? d_valid : i_valid), 64'(1));
            tick();
        end
        mem_valid = 1'b0;
        mem_out   = '0;
        tb_last_d = own_d;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        check({tag, "_valid"}, 64'({i_valid, d_valid}), 64'(0));
        check({tag, "_wait"}, 64'({i_wait, d_wait}), 64'({i_req, d_req}));
        #1;
        check({tag, "_sb_empty"}, 64'(gq.size() + bq.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     w;
        grant_t g;
        beat_t  b;

        rst = 1'b1;
        {i_req, i_write, i_burst, d_req, d_write, d_burst} = '0;
        {i_addr, d_addr, i_type, d_type, i_in, d_in, i_strobe, d_strobe} = '0;
        {mem_out, mem_wait, mem_valid} = '0;

        // Reset values
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_burst", 64'(mem_burst), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_in", mem_in, 64'(0));
        check("rst_mem_type", 64'(mem_type), 64'(0));
        check("rst_mem_strobe", 64'(mem_strobe), 64'(0));
        check("rst_valid", 64'({i_valid, d_valid}), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // D burst read
        d_addr = 32'h0000_1040; d_write = 1'b0; d_burst = 1'b1; d_type = 3'd2;
        d_in = 64'h1111_2222_3333_4444; d_strobe = 8'hFF; d_req = 1'b1;
        serve(1'b1, 0, 1'b0, 1'b0, 1'b0, 64'hA5A5_0000_0000_0010);
        d_req = 1'b0;
        idle_check("d_burst_done");

        // Simultaneous I and D, loser served after the winner completes
        d_addr = 32'h0000_2000; d_burst = 1'b0; d_type = 3'd1;
        i_addr = 32'h0000_3000; i_write = 1'b0; i_burst = 1'b1; i_type = 3'd3;
        i_in = 64'h5555_6666_7777_8888; i_strobe = 8'hF0;
        d_req = 1'b1; i_req = 1'b1;
        w = pick_d();
        serve(w, 0, 1'b0, 1'b0, 1'b0, 64'hB000_0000_0000_0020);
        if (w) d_req = 1'b0; else i_req = 1'b0;
        serve(!w, 0, 1'b0, 1'b0, 1'b0, 64'hB000_0000_0000_0030);
        i_req = 1'b0; d_req = 1'b0;
        idle_check("pair_done");

        // Both requesters held continuously for eight grants
        d_req = 1'b1; i_req = 1'b1;
        for (int r = 0; r < 8; r++) begin
            d_addr = 32'h0000_4000 + 32'(r * 16);
            i_addr = 32'h0000_5000 + 32'(r * 16);
            w = pick_d();
            serve(w, 0, 1'b0, 1'b0, 1'b0, 64'hC000_0000_0000_0000 + 64'(r * 4));
        end
        d_req = 1'b0; i_req = 1'b0;
        idle_check("contend_done");

        // D write with three stall cycles
        d_addr = 32'h1000_0000; d_write = 1'b1; d_burst = 1'b1; d_strobe = 8'h0F;
        d_in = 64'hDEAD_BEEF_0BAD_F00D; d_type = 3'd5; d_req = 1'b1;
        req_cycles = 0;
        serve(1'b1, 3, 1'b0, 1'b0, 1'b0, 64'hD000_0000_0000_0000);
        d_req = 1'b0;
        check("write_req_cycles", 64'(req_cycles), 64'(4));
        idle_check("write_done");

        // Owner drops after grant; I pulses a request that never reaches IDLE
        d_addr = 32'h0000_6000; d_write = 1'b0; d_burst = 1'b1; d_strobe = 8'hFF; d_req = 1'b1;
        serve(1'b1, 1, 1'b0, 1'b1, 1'b1, 64'hE000_0000_0000_0000);
        idle_check("drop_idle0");
        idle_check("drop_idle1");

        // Reset in RESP after the first beat of an I burst
        i_addr = 32'h0000_8000; i_write = 1'b0; i_burst = 1'b1; i_req = 1'b1;
        g = make_grant(1'b0);
        gq.push_back(g);
        tick();
        tick();
        mem_valid = 1'b1; mem_out = 64'hF000_0000_0000_0001;
        b.own_d = 1'b0; b.data = mem_out;
        bq.push_back(b);
        @(negedge clk);
        check("abort_beat1_valid", 64'(i_valid), 64'(1));
        check("abort_beat1_wait", 64'(i_wait), 64'(1));
        tick();
        rst = 1'b1; i_req = 1'b0; mem_out = 64'hF000_0000_0000_0002;
        @(negedge clk);
        check("abort_mem_req", 64'(mem_req), 64'(0));
        check("abort_valid", 64'({i_valid, d_valid}), 64'(0));
        tick();
        rst = 1'b0; mem_valid = 1'b0; mem_out = '0;
        tb_last_d = 1'b0;
        idle_check("abort_idle0");
        idle_check("abort_idle1");

        // After reset both request: D is favoured in either arbitration mode
        d_addr = 32'h0000_9000; d_write = 1'b0; d_burst = 1'b0; d_req = 1'b1;
        i_addr = 32'h0000_A000; i_burst = 1'b0; i_req = 1'b1;
        w = pick_d();
        serve(w, 0, 1'b0, 1'b0, 1'b0, 64'h1200_0000_0000_0000);
        if (w) d_req = 1'b0; else i_req = 1'b0;
        serve(!w, 0, 1'b0, 1'b0, 1'b0, 64'h1300_0000_0000_0000);
        i_req = 1'b0; d_req = 1'b0;
        idle_check("post_rst_done");

        // Stray mem_valid in IDLE and during ISSUE
        mem_valid = 1'b1; mem_out = 64'h7777_0000_0000_0000;
        idle_check("stray_idle");
        mem_valid = 1'b0;
        d_addr = 32'h0000_B000; d_burst = 1'b1; d_req = 1'b1;
        serve(1'b1, 1, 1'b1, 1'b0, 1'b0, 64'h1400_0000_0000_0000);
        d_req = 1'b0;
        idle_check("stray_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
